// File: rtl/mux3_arb_pkg.sv
// Shared types and constants for the three-way round-robin mux arbiter.
// Used by mux3_arbiter and rr_pick3.
package mux3_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   localparam logic [1:0] SEL_A   = 2'd0;
   localparam logic [1:0] SEL_B   = 2'd1;
   localparam logic [1:0] SEL_C   = 2'd2;

   // Pointer starts on the last requester so requester 0 is searched first.
   localparam logic [1:0] PTR_RST = SEL_C;

   // Index 3 never occurs; it maps to an empty mask instead of an out-of-range bit.
   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == SEL_C) ? SEL_A : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search order is ptr+1, ptr+2, then ptr itself (mod 3).
module rr_pick3
   import mux3_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] win
);

   logic [1:0] cand_1;
   logic [1:0] cand_2;

   assign cand_1 = next_idx(ptr);
   assign cand_2 = next_idx(cand_1);

   always_comb begin
      valid = 1'b1;
      win   = ptr;
      if (|(req & onehot3(cand_1))) begin
         win = cand_1;
      end else if (|(req & onehot3(cand_2))) begin
         win = cand_2;
      end else if (|(req & onehot3(ptr))) begin
         win = ptr;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/mux3_arbiter.sv
// Round-robin owner arbiter for a shared 3:1 mux; registered one-hot grant and select.
// Optional forced hand-off after MAX_HOLD owner cycles: define MUX3_ARB_TIMEOUT_EN.
module mux3_arbiter
   import mux3_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   output logic [2:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       preempt
);

   if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << CNT_W) <= MAX_HOLD) begin : g_param_check
      $error("mux3_arbiter: MAX_HOLD must be 2..15 and fit in CNT_W bits");
   end

   arb_state_e       state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [2:0]       gnt_d;
   logic [1:0]       sel_d;
   logic             busy_d;
   logic             preempt_d;

   logic             pick_valid;
   logic [1:0]       pick_win;
   logic             owner_req;
   logic             timeout_hit;

   rr_pick3 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .win   (pick_win)
   );

   // While owning, ptr_q is the owner's index.
   assign owner_req = |(req & onehot3(ptr_q));

`ifdef MUX3_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   logic others_req;
   assign others_req  = |(req & ~onehot3(ptr_q));
   assign timeout_hit = (state_q == ARB_OWN) && owner_req && others_req &&
                        (hold_q == HOLD_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gnt_d     = gnt;
      sel_d     = sel;
      busy_d    = busy;
      preempt_d = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_OWN;
               ptr_d   = pick_win;
               gnt_d   = onehot3(pick_win);
               sel_d   = pick_win;
               busy_d  = 1'b1;
               hold_d  = '0;
            end
         end
         ARB_OWN: begin
            if (!owner_req || timeout_hit) begin
               // Owner's own request is searched last, so a forced hand-off lands elsewhere.
               if (pick_valid) begin
                  ptr_d     = pick_win;
                  gnt_d     = onehot3(pick_win);
                  sel_d     = pick_win;
                  busy_d    = 1'b1;
                  hold_d    = '0;
                  preempt_d = timeout_hit;
               end else begin
                  state_d = ARB_IDLE;
                  gnt_d   = 3'b000;
                  busy_d  = 1'b0;
                  hold_d  = '0;
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = 3'b000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= PTR_RST;
         hold_q  <= '0;
         gnt     <= 3'b000;
         sel     <= SEL_A;
         busy    <= 1'b0;
         preempt <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt     <= gnt_d;
         sel     <= sel_d;
         busy    <= busy_d;
         preempt <= preempt_d;
      end
   end

endmodule

// File: tb/tb_mux3_arbiter.sv
// Directed scoreboard bench for mux3_arbiter; exercises the MUX3_ARB_TIMEOUT_EN
// path when that macro is defined, otherwise the hold-forever behaviour.
module tb_mux3_arbiter;

   localparam int W = 7;  // {gnt[2:0], sel[1:0], busy, preempt}

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       preempt;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mux3_arbiter #(
      .MAX_HOLD (4),
      .CNT_W    (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .preempt (preempt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge: drives req, queues the outputs expected after
   // the next rising edge, then advances to the following falling edge.
   task automatic cyc(input logic [2:0] r, input logic [2:0] g, input logic [1:0] s,
                      input logic b, input logic p);
      req = r;
      exp_q.push_back({g, s, b, p});
      @(negedge clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt",     32'(gnt),     32'(e[6:4]));
            check("sel",     32'(sel),     32'(e[3:2]));
            check("busy",    32'(busy),    32'(e[1]));
            check("preempt", 32'(preempt), 32'(e[0]));
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: stimulus did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      req = 3'b000;
      repeat (2) @(negedge clk);
      check("reset_gnt",  32'(gnt),  32'd0);
      check("reset_sel",  32'(sel),  32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_pre",  32'(preempt), 32'd0);
      rst = 1'b0;

      // All three request: 0 first, then hand-offs on each release.
      cyc(3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
      cyc(3'b111, 3'b001, 2'd0, 1'b1, 1'b0);
      cyc(3'b110, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b100, 3'b100, 2'd2, 1'b1, 1'b0);

      // Lone requester 2 holds; no competitor so no forced hand-off.
      for (int i = 0; i < 20; i++) cyc(3'b100, 3'b100, 2'd2, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
      cyc(3'b000, 3'b000, 2'd2, 1'b0, 1'b0);

      // Owner 1 releases with 0 and 2 pending: 2 wins on the same edge.
      cyc(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
      cyc(3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
      cyc(3'b110, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 2'd2, 1'b0, 1'b0);

      // Async reset in the middle of a grant to requester 1.
      cyc(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      req = 3'b110;
      #1;
      check("async_rst_gnt",  32'(gnt),  32'd0);
      check("async_rst_sel",  32'(sel),  32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(3'b110, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 2'd1, 0, 1'b0);

      // Owner 0 holds while requester 1 waits.
      cyc(3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
`ifdef MUX3_ARB_TIMEOUT_EN
      for (int i = 0; i < 3; i++) cyc(3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
      cyc(3'b011, 3'b010, 2'd1, 1'b1, 1'b1);
      cyc(3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
`else
      for (int i = 0; i < 50; i++) cyc(3'b011, 3'b001, 2'd0, 1'b1, 1'b0);
      cyc(3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
